// File: rtl/sha_mem_responder.sv
// sha_mem_responder: word-addressed memory responder for the SHA-256 hash engine.
// A host streams NUM_OF_WORDS message words in; the block then pulses eng_start,
// serves the engine's mem_* bus until eng_done, and streams the 8 hash words out.
//
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   in_valid/in_ready/in_data    host message word stream (in_ready combinational)
//   out_valid/out_ready/out_data hash word stream, h0 first
//   busy                    high whenever the FSM is not in LOAD
//   err                     sticky out-of-range access flag
//   eng_start, eng_done     engine control (done is a level, high while idle)
//   eng_message_addr/eng_output_addr  constant base addresses for the engine
//   mem_we/mem_addr/mem_write_data/mem_read_data  engine memory bus
//
// Build option: define SHA_RESP_ERR_EN to range-check every access and drive err;
// without it addresses wrap modulo MEM_DEPTH and err is tied low.
module sha_mem_responder #(
   parameter int unsigned NUM_OF_WORDS = 20,
   parameter int unsigned MEM_DEPTH    = 64,
   parameter int unsigned MSG_BASE     = 0,
   parameter int unsigned OUT_BASE     = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        in_ready,
   output logic        out_valid,
   output logic [31:0] out_data,
   input  logic        out_ready,
   output logic        busy,
   output logic        err,
   output logic        eng_start,
   input  logic        eng_done,
   output logic [15:0] eng_message_addr,
   output logic [15:0] eng_output_addr,
   input  logic        mem_we,
   input  logic [15:0] mem_addr,
   input  logic [31:0] mem_write_data,
   output logic [31:0] mem_read_data
);

   localparam int unsigned AW      = $clog2(MEM_DEPTH);
   localparam int unsigned CNT_MAX = (NUM_OF_WORDS > 8) ? NUM_OF_WORDS : 8;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_LOAD,
      S_START,
      S_WAIT_BUSY,
      S_SERVE,
      S_FETCH,
      S_PRESENT
   } state_t;

   state_t         state, state_d;
   logic [CW-1:0]  count, count_d;
   logic           out_valid_d;
   logic [31:0]    out_data_d;

   logic [15:0]    msg_addr, out_addr, wr_addr;
   logic [31:0]    wr_data, rd_data, fetch_data;
   logic           load_we, eng_we, wr_req;
   logic           wr_ok, rd_ok, fetch_ok;

   logic [31:0]    mem [MEM_DEPTH];

   assign eng_message_addr = 16'(MSG_BASE);
   assign eng_output_addr  = 16'(OUT_BASE);
   assign in_ready         = (state == S_LOAD);

   // Address generation and write-port arbitration (load and engine writes never overlap by state)
   always_comb begin
      msg_addr = 16'(MSG_BASE) + 16'(count);
      out_addr = 16'(OUT_BASE) + 16'(count);
      load_we  = (state == S_LOAD) && in_valid;
      eng_we   = (state == S_SERVE) && mem_we && !eng_done;
      wr_req   = load_we || eng_we;
      wr_addr  = load_we ? msg_addr : mem_addr;
      wr_data  = load_we ? in_data  : mem_write_data;
   end

`ifdef SHA_RESP_ERR_EN
   function automatic logic in_range(input logic [15:0] a);
      return (32'(a) < MEM_DEPTH);
   endfunction

   assign wr_ok    = in_range(wr_addr);
   assign rd_ok    = in_range(mem_addr);
   assign fetch_ok = in_range(out_addr);

   // Sticky error: engine-port reads happen every cycle, so any out-of-range mem_addr counts
   always_ff @(posedge clk) begin
      if (reset) begin
         err <= 1'b0;
      end else if (!rd_ok || (wr_req && !wr_ok) || ((state == S_FETCH) && !fetch_ok)) begin
         err <= 1'b1;
      end
   end
`else
   logic unused_hi;

   assign wr_ok     = 1'b1;
   assign rd_ok     = 1'b1;
   assign fetch_ok  = 1'b1;
   assign err       = 1'b0;
   // Upper address bits are dropped when addresses wrap
   assign unused_hi = ^{wr_addr[15:AW], out_addr[15:AW], mem_addr[15:AW]};
`endif

   assign rd_data    = rd_ok    ? mem[mem_addr[AW-1:0]] : 32'h0;
   assign fetch_data = fetch_ok ? mem[out_addr[AW-1:0]] : 32'h0;

   // Storage write port; contents are not reset
   always_ff @(posedge clk) begin
      if (!reset && wr_req && wr_ok) begin
         mem[wr_addr[AW-1:0]] <= wr_data;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_LOAD;
         count         <= '0;
         out_valid     <= 1'b0;
         out_data      <= '0;
         eng_start     <= 1'b0;
         busy          <= 1'b0;
         mem_read_data <= '0;
      end else begin
         state         <= state_d;
         count         <= count_d;
         out_valid     <= out_valid_d;
         out_data      <= out_data_d;
         eng_start     <= (state_d == S_START);
         busy          <= (state_d != S_LOAD);
         mem_read_data <= rd_data;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state;
      count_d     = count;
      out_valid_d = out_valid;
      out_data_d  = out_data;

      case (state)
         S_LOAD: begin
            if (in_valid) begin
               if (count == CW'(NUM_OF_WORDS - 1)) begin
                  count_d = '0;
                  state_d = S_START;
               end else begin
                  count_d = count + CW'(1);
               end
            end
         end
         S_START: begin
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (!eng_done) state_d = S_SERVE;
         end
         S_SERVE: begin
            if (eng_done) begin
               count_d = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            out_data_d  = fetch_data;
            out_valid_d = 1'b1;
            state_d     = S_PRESENT;
         end
         S_PRESENT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (count == CW'(7)) begin
                  count_d = '0;
                  state_d = S_LOAD;
               end else begin
                  count_d = count + CW'(1);
                  state_d = S_FETCH;
               end
            end
         end
         default: begin
            state_d = S_LOAD;
            count_d = '0;
         end
      endcase
   end

endmodule

// File: doc/sha_mem_responder.md
Name: sha_mem_responder

Overview:
Word-addressed memory responder that sits on the memory side of the SHA-256/bitcoin hash engine and serves its mem_* request bus.
A host loads the message words through a valid/ready input stream. The block then pulses the engine's start and serves its reads and writes.
When the engine raises done, the block streams the 8 hash words back to the host through a valid/ready output stream.

Parameters:
NUM_OF_WORDS, 20, message words loaded per job; must match the engine.
MEM_DEPTH, 64, storage depth in 32-bit words; power of two.
MSG_BASE, 0, word address of message word 0; driven on eng_message_addr.
OUT_BASE, 32, word address of hash word h0; driven on eng_output_addr.

Ports:
clk  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  host message word valid
in_data  in  32  host message word
in_ready  out  1  block accepts in_data
out_valid  out  1  hash word valid
out_data  out  32  hash word, h0 first
out_ready  in  1  host accepts out_data
busy  out  1  high whenever state is not LOAD
err  out  1  sticky out-of-range access flag (SHA_RESP_ERR_EN only; tied 0 otherwise)
eng_start  out  1  one-cycle start pulse to engine
eng_done  in  1  engine done (level; high while engine idle)
eng_message_addr  out  16  constant MSG_BASE
eng_output_addr  out  16  constant OUT_BASE
mem_we  in  1  engine write enable
mem_addr  in  16  engine word address
mem_write_data  in  32  engine write data
mem_read_data  out  32  registered read data

Behaviour:
- Storage: MEM_DEPTH x 32 array. Contents are not reset and survive reset.
- Reset: state=LOAD, word count=0. in_ready=1 (combinational from LOAD), out_valid=0, out_data=0, eng_start=0, mem_read_data=0, err=0.
- Read port:
  - mem_read_data <= mem[mem_addr] every cycle in every state, giving 1-cycle latency.
  - A same-cycle read and write to the same address returns the old data.
- Engine writes:
  - Committed only when state==SERVE and mem_we==1 and eng_done==0.
  - mem_we in any other state or cycle is ignored. This drops the engine's trailing write after it returns to idle.
- FSM:
  - LOAD:
    - in_ready=1.
    - Each in_valid&&in_ready writes mem[MSG_BASE+count], then count++.
    - On the NUM_OF_WORDS-th accept: count=0, go START. in_ready is 0 from the next cycle.
  - START: eng_start=1 for exactly this cycle, then go WAIT_BUSY.
  - WAIT_BUSY: hold until eng_done==0, then go SERVE. A done that stays high is waited on indefinitely.
  - SERVE: serve reads and writes; when eng_done==1, count=0 and go FETCH.
  - FETCH:
    - Uses the read port: out_data <= mem[OUT_BASE+count], out_valid <= 1.
    - Then go PRESENT.
    - The engine is idle here, so the read port is free.
  - PRESENT:
    - Hold out_valid and out_data stable until out_ready.
    - On handshake: out_valid <= 0, count++.
    - If count was 7, go LOAD; otherwise go FETCH.
    - Throughput is one word per 2 cycles at best.
- Address arithmetic: MSG_BASE+count and OUT_BASE+count use 16-bit unsigned addition, then the out-of-range rule below applies.
- Reset mid-operation (any state): immediate return to LOAD with count=0. Any in-flight word is discarded, out_valid drops, and err clears.

Optional Feature:
SHA_RESP_ERR_EN
- Defined:
  - Any read, write or internal access with address >= MEM_DEPTH sets err (sticky until reset).
  - Such reads return 0; such writes are dropped.
- Undefined:
  - Addresses are used modulo MEM_DEPTH (low bits only) and err is tied 0.

Test Plan:
- Assert reset 2 cycles -> in_ready=1, out_valid=0, eng_start=0, busy=0, mem_read_data=0.
- Stream 0x0..0x13 on in_data with in_valid held -> 20 accepts; in_ready=0 the next cycle; eng_start high exactly one cycle; busy=1.
- Stub engine (done dropped) drives mem_addr=5 -> mem_read_data=0x5 next cycle. Write 0xDEADBEEF to address 33 while reading 33 -> old value the next cycle, 0xDEADBEEF the cycle after.
- Stub writes 0x10..0x17 to 32..39, then raises done with mem_we=1, addr=0, data=0xFFFFFFFF. Expected:
  - mem[0] stays 0x0.
  - Output stream is 0x10..0x17 in order with out_ready toggling 1/0; data is held while out_ready=0.
  - busy drops after the 8th handshake.
- Assert reset after 10 loaded words -> back to LOAD. Next load writes address 0 first (read back 0xA5A5A5A5 via the stub).
- With SHA_RESP_ERR_EN, mem_addr=64 in SERVE -> err=1 and stays set; read returns 0. Without it -> returns mem[0], err=0.
